// File: rtl/periph_apb_bridge.sv
// periph_apb_bridge
// Converts a single-beat req/gnt request into one APB transfer
// (SETUP -> ACCESS) and returns the result as a one-cycle response strobe.
// A response cycle may also accept the next request, so back-to-back
// traffic runs at one transfer every three cycles.
//
// Optional build macro: PERIPH_APB_TIMEOUT_EN
//   defined   - an ACCESS watchdog ends a transfer with an error response
//               (r_opc_o=1, r_rdata_o=0) once TIMEOUT_CYCLES ACCESS cycles
//               pass without pready_i. pready_i in the final cycle still
//               completes the transfer normally.
//   undefined - no counter; ACCESS waits for pready_i indefinitely.

module periph_apb_bridge #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    // SoC-side request / response
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic                      we_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      r_valid_o,
    output logic [APB_DATA_WIDTH-1:0] r_rdata_o,
    output logic                      r_opc_o,

    // APB master
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    output logic                      pwrite_o,
    output logic                      psel_o,
    output logic                      penable_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    // The watchdog limit is a count of ACCESS cycles, so zero is meaningless.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("periph_apb_bridge: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e                      state_q,  state_d;
    logic [APB_ADDR_WIDTH-1:0]   paddr_q,  paddr_d;
    logic [APB_DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic                        pwrite_q, pwrite_d;
    logic [APB_DATA_WIDTH-1:0]   rdata_q,  rdata_d;
    logic                        opc_q,    opc_d;
    logic                        grant;

`ifdef PERIPH_APB_TIMEOUT_EN
    // Wide enough to hold TIMEOUT_CYCLES-1, the last value before expiry.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // Next-state, request acceptance and response capture.
    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        rdata_d  = rdata_q;
        opc_d    = opc_q;
        grant    = 1'b0;
`ifdef PERIPH_APB_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    grant   = 1'b1;
                    state_d = SETUP;
                end
            end

            SETUP: begin
                state_d = ACCESS;
`ifdef PERIPH_APB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end

            ACCESS: begin
                if (pready_i) begin
                    // Writes return zero so stale bus data never leaks out.
                    rdata_d = pwrite_q ? '0 : prdata_i;
                    opc_d   = pslverr_i;
                    state_d = RESP;
                end
`ifdef PERIPH_APB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    // This is the TIMEOUT_CYCLES-th ACCESS cycle without
                    // pready_i: give up and report an error.
                    rdata_d = '0;
                    opc_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`else
                // No watchdog: hold ACCESS until the slave answers.
`endif
            end

            RESP: begin
                // The response cycle doubles as a grant slot for the next request.
                if (req_i) begin
                    grant   = 1'b1;
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Request fields are latched only when accepted and then held for
        // the whole transfer.
        if (grant) begin
            paddr_d  = addr_i;
            pwdata_d = wdata_i;
            pwrite_d = we_i;
        end
    end

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            rdata_q  <= '0;
            opc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            rdata_q  <= rdata_d;
            opc_q    <= opc_d;
        end
    end

`ifdef PERIPH_APB_TIMEOUT_EN
    // ACCESS watchdog counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    // APB strobes and the response strobe decode straight from the state
    // register, so an asynchronous reset drops them immediately.
    always_comb begin
        gnt_o     = grant;
        psel_o    = (state_q == SETUP) || (state_q == ACCESS);
        penable_o = (state_q == ACCESS);
        r_valid_o = (state_q == RESP);
        paddr_o   = paddr_q;
        pwdata_o  = pwdata_q;
        pwrite_o  = pwrite_q;
        r_rdata_o = rdata_q;
        r_opc_o   = opc_q;
    end

endmodule
